// File: rtl/data_ram_bank.sv
// Byte-lane RAM bank with a one-deep response register and a
// sweep engine that zeroes every word after reset or on request.
module data_ram_bank #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_start,
    output logic                busy,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_sel,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int LANES = DATA_W / 8;
    localparam int OFS   = $clog2(LANES);
    localparam int IDX   = $clog2(DEPTH);
    localparam int TOP   = IDX + OFS;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX-1:0]   cnt;
    logic [IDX-1:0]   cnt_nxt;
    logic             pend;
    logic             pend_nxt;
    logic             boot;
    logic             boot_nxt;
    logic [IDX-1:0]   idx;
    logic             oor;
    logic             free;
    logic             acc;
    logic [DATA_W-1:0] mem [DEPTH];

    assign idx       = req_addr[TOP-1:OFS];
    assign oor       = |(req_addr >> TOP);
    assign free      = !rsp_valid || rsp_ready;
    // boot holds off requests for the first cycle out of reset
    assign req_ready = (state == IDLE) && !boot && free;
    assign acc       = req_valid && req_ready;
    assign busy      = (state == CLEAR);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        boot_nxt  = boot;
        unique case (state)
            IDLE: begin
                if (boot) begin
                    boot_nxt  = 1'b0;
                    state_nxt = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
                end else if (free && (pend || (clr_start && !acc))) begin
                    pend_nxt  = 1'b0;
                    state_nxt = CLEAR;
                end else if (clr_start) begin
                    pend_nxt = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt == IDX'(DEPTH - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + IDX'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
            boot  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            boot  <= boot_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (acc) begin
            rsp_valid <= 1'b1;
            rsp_err   <= oor;
            rsp_rdata <= (req_we || oor) ? '0 : mem[idx];
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // storage is deliberately not reset; the sweep handles clearing
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (acc && req_we && !oor) begin
            for (int i = 0; i < LANES; i++) begin
                if (req_sel[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_ram_bank.md
DATA_RAM_BANK -- requirements
Module: data_ram_bank

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter DEPTH, default 1024, number of words; SHALL be a power of two, minimum 2.
REQ-004 Parameter CLEAR_ON_RESET, default 1; 1 = automatic memory clear after reset release.
REQ-005 Derived: LANES = DATA_W/8; OFS = log2(LANES); IDX = log2(DEPTH).
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 clr_start  input  1  one-cycle pulse requesting a full memory clear.
REQ-009 busy  output  1  high while a clear sweep is in progress.
REQ-010 req_valid  input  1  request present.
REQ-011 req_ready  output  1  request accepted when req_valid & req_ready.
REQ-012 req_we  input  1  1 = write, 0 = read.
REQ-013 req_addr  input  ADDR_W  byte address.
REQ-014 req_sel  input  LANES  byte-lane enables, bit i = data[8i+7:8i].
REQ-015 req_wdata  input  DATA_W  write data.
REQ-016 rsp_valid  output  1  response present.
REQ-017 rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
REQ-018 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-019 rsp_err  output  1  request address out of range.

Function
REQ-020 Word index SHALL be req_addr[IDX+OFS-1:OFS]; req_addr[OFS-1:0] SHALL be ignored.
REQ-021 A request with any of req_addr[ADDR_W-1:IDX+OFS] set SHALL be out of range: no memory write, response with rsp_err=1, rsp_rdata=0.
REQ-022 FSM states: IDLE (serve requests), CLEAR (sweep); single one-word response register with its own rsp_valid flag.
REQ-023 In IDLE, req_ready SHALL equal (!rsp_valid | rsp_ready); in CLEAR, req_ready SHALL be 0.
REQ-024 Accepted write: lanes with req_sel[i]=1 SHALL be written at the clock edge of acceptance; other lanes unchanged; req_sel=0 SHALL write nothing but still respond.
REQ-025 Accepted read: rsp_rdata SHALL present the stored word (all lanes, regardless of req_sel) with rsp_valid=1 on the cycle after acceptance (latency 1).
REQ-026 A read accepted the cycle after a write to the same index SHALL return the newly written bytes.
REQ-027 Every accepted request SHALL produce exactly one response, in acceptance order.
REQ-028 rsp_valid, rsp_rdata, rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-029 Simultaneous response consumption and new acceptance SHALL load the new response with no bubble (one request per cycle sustained).
REQ-030 rsp_valid SHALL clear on consumption when no new request is accepted that cycle.
REQ-031 clr_start in IDLE SHALL be honoured only when rsp_valid=0 or when the pending response is consumed that cycle; otherwise it SHALL be held as pending and honoured once that holds.
REQ-032 clr_start and an accepted request in the same cycle: the request SHALL be accepted first; the clear starts the cycle after its response is consumed.
REQ-033 CLEAR SHALL write 0 to word index 0..DEPTH-1, one word per cycle, with busy=1; after index DEPTH-1 the FSM SHALL return to IDLE with busy=0 the next cycle (DEPTH cycles total).
REQ-034 clr_start during CLEAR SHALL be ignored; the sweep counter SHALL not wrap or restart.

Reset
REQ-035 While rst=0: FSM=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=0, pending clear=0, sweep counter=0.
REQ-036 Memory contents SHALL not be reset by rst.
REQ-037 With CLEAR_ON_RESET=1, the first cycle after rst deasserts SHALL enter CLEAR; with 0, IDLE.
REQ-038 rst asserted mid-sweep or mid-response SHALL abort immediately; the in-flight response SHALL be lost; with CLEAR_ON_RESET=1 the sweep restarts from index 0.

Verification
REQ-039 Reset release, CLEAR_ON_RESET=1, DEPTH=1024 -> busy=1 for exactly 1024 cycles, req_ready=0 throughout, then reads of any index return 0x00000000.
REQ-040 Write addr 0x10, sel 4'b1111, data 0xDEADBEEF; then write addr 0x10, sel 4'b0101, data 0x11223344; read 0x10 -> rsp_rdata 0xDE22BE44 one cycle after acceptance, rsp_err=0.
REQ-041 Read addr 0x1000 (DEPTH=1024, DATA_W=32) -> rsp_err=1, rsp_rdata=0; prior write of 0x55 to addr 0x1000 leaves index 0 unchanged.
REQ-042 Back-to-back reads with rsp_ready=0 for 3 cycles -> req_ready=0 after first acceptance, response held stable, then one read per cycle once rsp_ready=1, responses in order.
REQ-043 clr_start while rsp_valid=1 and rsp_ready=0 -> no sweep until the response is consumed, then busy=1 for DEPTH cycles.
REQ-044 rst pulsed low at sweep index 500 -> busy=0 and rsp_valid=0 immediately; after release the sweep restarts at index 0 and completes in DEPTH cycles.
